// File: rtl/mux_arb_pkg.sv
// Shared types for the wormhole output-port arbiter: flit-type codes,
// arbiter states and the one-hot mux select values.
package mux_arb_pkg;

   localparam int TYPEW   = 2;
   localparam int PORT_P1 = 5;
   localparam int SELW    = PORT_P1;

   typedef enum logic [TYPEW-1:0] {
      TYPE_NONE = 2'd0,
      TYPE_HEAD = 2'd1,
      TYPE_DATA = 2'd2,
      TYPE_TAIL = 2'd3
   } flit_type_e;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_LOCK0 = 2'd1,
      ARB_LOCK1 = 2'd2
   } arb_state_e;

   localparam logic [SELW-1:0] SEL_NONE = 5'b00000;
   localparam logic [SELW-1:0] SEL_IN0  = 5'b00001;
   localparam logic [SELW-1:0] SEL_IN1  = 5'b00010;

endpackage

// File: rtl/mux_arb_if.sv
// Flit-control handshake between the two input buffers, the arbiter and
// the downstream link; the arbiter is the slave side.
interface mux_arb_if;
   import mux_arb_pkg::*;

   logic             ivalid_0;
   logic [TYPEW-1:0] itype_0;
   logic             ivalid_1;
   logic [TYPEW-1:0] itype_1;
   logic             iready;
   logic [SELW-1:0]  sel;
   logic             ordy_0;
   logic             ordy_1;
   logic             busy;
   logic             err;

   modport slave (
      input  ivalid_0, itype_0, ivalid_1, itype_1, iready,
      output sel, ordy_0, ordy_1, busy, err
   );

   modport master (
      output ivalid_0, itype_0, ivalid_1, itype_1, iready,
      input  sel, ordy_0, ordy_1, busy, err
   );

endinterface

// File: rtl/mux_arb_rr_pick2.sv
// Combinational two-request round-robin pick: a lone request wins, and on a
// tie the input that was not granted last wins.
module mux_arb_rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_pick
         assign gnt_o[gi] = req_i[gi] & (~req_i[1-gi] | (last_i != 1'(gi)));
      end
   endgenerate

endmodule

// File: rtl/mux_arb.sv
// Packet-level round-robin arbiter for the 2:1 router output mux: holds the
// grant from HEAD through TAIL so packets never interleave on the output.
module mux_arb
   import mux_arb_pkg::*;
(
   input  logic      clk,
   input  logic      rst_,
   mux_arb_if.slave  arb_if
);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic       err_q, err_d;
   logic       hd_q, hd_d;      // head of the current packet already moved

   logic [1:0]            valid;
   logic [1:0][TYPEW-1:0] itype;
   logic [1:0]            head_req;
   logic [1:0]            tail_flit;
   logic [1:0]            lock;
   logic [1:0]            ordy;
   logic [1:0]            xfer;
   logic [1:0]            gnt;
   logic                  own;

   assign valid = {arb_if.ivalid_1, arb_if.ivalid_0};
   assign itype = {arb_if.itype_1, arb_if.itype_0};
   assign lock  = {state_q == ARB_LOCK1, state_q == ARB_LOCK0};
   assign own   = (state_q == ARB_LOCK1);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_in
         assign head_req[gi]  = valid[gi] & (itype[gi] == TYPE_HEAD);
         assign tail_flit[gi] = (itype[gi] == TYPE_TAIL);
         assign ordy[gi]      = lock[gi] & arb_if.iready;
         assign xfer[gi]      = valid[gi] & ordy[gi];
      end
   endgenerate

   mux_arb_rr_pick2 u_pick (
      .req_i  (head_req),
      .last_i (last_q),
      .gnt_o  (gnt)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      err_d   = err_q;
      hd_d    = hd_q;
      case (state_q)
         ARB_IDLE: begin
            hd_d = 1'b0;
            if (gnt[0]) begin
               state_d = ARB_LOCK0;
               last_d  = 1'b0;
            end else if (gnt[1]) begin
               state_d = ARB_LOCK1;
               last_d  = 1'b1;
            end
            if ((valid & ~head_req) != 2'b00) begin
               err_d = 1'b1;
            end
         end
         ARB_LOCK0, ARB_LOCK1: begin
            // A HEAD after this packet's own head means the tail went missing.
            if (head_req[own] && hd_q) begin
               err_d = 1'b1;
            end
            if (xfer[own]) begin
               hd_d = 1'b1;
            end
            if (xfer[own] && tail_flit[own]) begin
               if (head_req[~own]) begin
                  state_d = own ? ARB_LOCK0 : ARB_LOCK1;
                  last_d  = ~own;
                  hd_d    = 1'b0;
               end else begin
                  state_d = ARB_IDLE;
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= ARB_IDLE;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         hd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         err_q   <= err_d;
         hd_q    <= hd_d;
      end
   end

   assign arb_if.sel    = lock[0] ? SEL_IN0 : (lock[1] ? SEL_IN1 : SEL_NONE);
   assign arb_if.ordy_0 = ordy[0];
   assign arb_if.ordy_1 = ordy[1];
   assign arb_if.busy   = (state_q != ARB_IDLE);
   assign arb_if.err    = err_q;

endmodule

// File: tb/tb_mux_arb.sv
// Directed-vector bench: each stimulus cycle queues its hand-computed
// expected outputs; a negedge monitor pops and compares them.
module tb_mux_arb;
   import mux_arb_pkg::*;

   logic clk;
   logic rst_;

   mux_arb_if u_if ();

   mux_arb u_dut (
      .clk    (clk),
      .rst_   (rst_),
      .arb_if (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {sel[4:0], ordy_0, ordy_1, busy}
   localparam logic [7:0] X_IDLE = 8'b00000_0_0_0;
   localparam logic [7:0] X_L0   = 8'b00001_1_0_1;
   localparam logic [7:0] X_L0W  = 8'b00001_0_0_1;
   localparam logic [7:0] X_L1   = 8'b00010_0_1_1;

   logic [8:0] exp_q[$];
   string      nm_q[$];
   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;

   task automatic step(input logic r, input logic v0, input logic [1:0] t0,
                       input logic v1, input logic [1:0] t1, input logic rdy,
                       input logic [7:0] ex, input logic ee, input string nm);
      @(posedge clk);
      #1;
      rst_        = r;
      u_if.ivalid_0 = v0;
      u_if.itype_0  = t0;
      u_if.ivalid_1 = v1;
      u_if.itype_1  = t1;
      u_if.iready   = rdy;
      cyc++;
      exp_q.push_back({ex, ee});
      nm_q.push_back(nm);
   endtask

   always @(negedge clk) begin
      logic [8:0] e;
      logic [8:0] got;
      string      n;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         n   = nm_q.pop_front();
         got = {u_if.sel, u_if.ordy_0, u_if.ordy_1, u_if.busy, u_if.err};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got sel=%b o0=%b o1=%b busy=%b err=%b exp sel=%b o0=%b o1=%b busy=%b err=%b",
                     n, cyc, got[8:4], got[3], got[2], got[1], got[0],
                     e[8:4], e[3], e[2], e[1], e[0]);
         end else begin
            $display("ok   %s cyc=%0d sel=%b o0=%b o1=%b busy=%b err=%b",
                     n, cyc, got[8:4], got[3], got[2], got[1], got[0]);
         end
      end
   end

   initial begin
      rst_          = 1'b0;
      u_if.ivalid_0 = 1'b0;
      u_if.itype_0  = TYPE_NONE;
      u_if.ivalid_1 = 1'b0;
      u_if.itype_1  = TYPE_NONE;
      u_if.iready   = 1'b1;

      step(0, 0, TYPE_NONE, 0, TYPE_NONE, 1, X_IDLE, 0, "reset");
      step(1, 0, TYPE_NONE, 0, TYPE_NONE, 1, X_IDLE, 0, "idle");

      // Long packet on input 1: 22 locked cycles, then idle.
      step(1, 0, TYPE_NONE, 1, TYPE_HEAD, 1, X_IDLE, 0, "t1_req");
      step(1, 0, TYPE_NONE, 1, TYPE_HEAD, 1, X_L1, 0, "t1_head");
      for (int i = 0; i < 20; i++)
         step(1, 0, TYPE_NONE, 1, TYPE_DATA, 1, X_L1, 0, "t1_data");
      step(1, 0, TYPE_NONE, 1, TYPE_TAIL, 1, X_L1, 0, "t1_tail");
      step(1, 0, TYPE_NONE, 0, TYPE_NONE, 1, X_IDLE, 0, "t1_done");

      // Tie goes to input 0 (last=1), zero-bubble handover to input 1.
      step(1, 1, TYPE_HEAD, 1, TYPE_HEAD, 1, X_IDLE, 0, "t2_tie");
      step(1, 1, TYPE_HEAD, 1, TYPE_HEAD, 1, X_L0, 0, "t2_p0h");
      step(1, 1, TYPE_DATA, 1, TYPE_HEAD, 1, X_L0, 0, "t2_p0d");
      step(1, 1, TYPE_TAIL, 1, TYPE_HEAD, 1, X_L0, 0, "t2_p0t");
      step(1, 0, TYPE_NONE, 1, TYPE_HEAD, 1, X_L1, 0, "t2_p1h");
      step(1, 0, TYPE_NONE, 1, TYPE_DATA, 1, X_L1, 0, "t2_p1d");
      step(1, 0, TYPE_NONE, 1, TYPE_TAIL, 1, X_L1, 0, "t2_p1t");
      step(1, 1, TYPE_HEAD, 1, TYPE_HEAD, 1, X_IDLE, 0, "t2_tie2");
      step(1, 1, TYPE_HEAD, 1, TYPE_HEAD, 1, X_L0, 0, "t2_q0h");
      step(1, 1, TYPE_TAIL, 1, TYPE_HEAD, 1, X_L0, 0, "t2_q0t");
      step(1, 0, TYPE_NONE, 1, TYPE_HEAD, 1, X_L1, 0, "t2_q1h");
      step(1, 0, TYPE_NONE, 1, TYPE_TAIL, 1, X_L1, 0, "t2_q1t");

      // Three 4-flit packets from input 0, one idle cycle between each.
      for (int p = 0; p < 3; p++) begin
         step(1, 1, TYPE_HEAD, 0, TYPE_NONE, 1, X_IDLE, 0, "t3_gap");
         step(1, 1, TYPE_HEAD, 0, TYPE_NONE, 1, X_L0, 0, "t3_h");
         step(1, 1, (p == 2) ? TYPE_NONE : TYPE_DATA, 0, TYPE_NONE, 1, X_L0, 0, "t3_d1");
         step(1, 1, TYPE_DATA, 0, TYPE_NONE, 1, X_L0, 0, "t3_d2");
         step(1, 1, TYPE_TAIL, 0, TYPE_NONE, 1, X_L0, 0, "t3_t");
      end
      step(1, 0, TYPE_NONE, 0, TYPE_NONE, 1, X_IDLE, 0, "t3_end");

      // iready 1,0,0,1 mid-packet: ordy follows, sel holds, tail 2 cycles late.
      step(1, 1, TYPE_HEAD, 0, TYPE_NONE, 1, X_IDLE, 0, "t4_req");
      step(1, 1, TYPE_HEAD, 0, TYPE_NONE, 1, X_L0, 0, "t4_h");
      step(1, 1, TYPE_DATA, 0, TYPE_NONE, 0, X_L0W, 0, "t4_w1");
      step(1, 1, TYPE_DATA, 0, TYPE_NONE, 0, X_L0W, 0, "t4_w2");
      step(1, 1, TYPE_DATA, 0, TYPE_NONE, 1, X_L0, 0, "t4_d1");
      step(1, 1, TYPE_DATA, 0, TYPE_NONE, 1, X_L0, 0, "t4_d2");
      step(1, 1, TYPE_TAIL, 0, TYPE_NONE, 1, X_L0, 0, "t4_t");
      step(1, 0, TYPE_NONE, 0, TYPE_NONE, 1, X_IDLE, 0, "t4_end");

      // DATA in IDLE: no grant, sticky err; second HEAD keeps the lock.
      step(1, 0, TYPE_NONE, 1, TYPE_DATA, 1, X_IDLE, 0, "t5_bad");
      step(1, 0, TYPE_NONE, 0, TYPE_NONE, 1, X_IDLE, 1, "t5_err");
      step(1, 1, TYPE_HEAD, 0, TYPE_NONE, 1, X_IDLE, 1, "t5_req");
      step(1, 1, TYPE_HEAD, 0, TYPE_NONE, 1, X_L0, 1, "t5_h");
      step(1, 1, TYPE_DATA, 0, TYPE_NONE, 1, X_L0, 1, "t5_d");
      step(1, 1, TYPE_HEAD, 0, TYPE_NONE, 1, X_L0, 1, "t5_h2");
      step(1, 1, TYPE_DATA, 0, TYPE_NONE, 1, X_L0, 1, "t5_held");
      step(1, 1, TYPE_TAIL, 0, TYPE_NONE, 1, X_L0, 1, "t5_t");
      step(1, 0, TYPE_NONE, 0, TYPE_NONE, 1, X_IDLE, 1, "t5_end");

      // Async reset mid-packet, then a fresh packet with a missing tail.
      step(1, 1, TYPE_HEAD, 0, TYPE_NONE, 1, X_IDLE, 1, "t6_req");
      step(1, 1, TYPE_HEAD, 0, TYPE_NONE, 1, X_L0, 1, "t6_h");
      step(1, 1, TYPE_DATA, 0, TYPE_NONE, 1, X_L0, 1, "t6_d");
      step(0, 1, TYPE_DATA, 0, TYPE_NONE, 1, X_IDLE, 0, "t6_async");
      step(1, 0, TYPE_NONE, 0, TYPE_NONE, 1, X_IDLE, 0, "t6_rel");
      step(1, 0, TYPE_NONE, 1, TYPE_HEAD, 1, X_IDLE, 0, "t6_req2");
      step(1, 0, TYPE_NONE, 1, TYPE_HEAD, 1, X_L1, 0, "t6_h");
      step(1, 0, TYPE_NONE, 1, TYPE_DATA, 1, X_L1, 0, "t6_d");
      step(1, 0, TYPE_NONE, 1, TYPE_HEAD, 1, X_L1, 0, "t6_h2");
      step(1, 0, TYPE_NONE, 1, TYPE_DATA, 1, X_L1, 1, "t6_err");
      step(1, 0, TYPE_NONE, 1, TYPE_TAIL, 1, X_L1, 1, "t6_t");
      step(1, 0, TYPE_NONE, 0, TYPE_NONE, 1, X_IDLE, 1, "t6_end");

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got pending=%0d exp pending=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
